// File: rtl/udp_tx_arb_pkg.sv
// Shared definitions for the UDP TX two-channel packet arbiter.
//   arb_state_t : FSM state encoding (3 bits)
//   CH0 / CH1   : channel index constants, also bit positions in a one-hot grant
//   GAP_CNT_W   : width of the inter-packet gap down-counter
//   ch_onehot   : channel index -> one-hot grant vector
package udp_tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_FWD      = 3'd3,
        ST_GAP      = 3'd4
    } arb_state_t;

    localparam int unsigned CH0       = 0;
    localparam int unsigned CH1       = 1;
    localparam int unsigned GAP_CNT_W = 8;

    function automatic logic [1:0] ch_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// AXI-Stream bundle used by the UDP TX arbiter (64-bit data, 32-bit user).
//   data/user/keep/last/valid : driven by the master
//   ready                     : driven by the slave
interface udp_tx_axis_if;
    logic [63:0] data;
    logic [31:0] user;
    logic [7:0]  keep;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, output user, output keep, output last, output valid,
                    input  ready);
    modport slave  (input  data, input  user, input  keep, input  last, input  valid,
                    output ready);
endinterface

// File: rtl/udp_tx_arbiter_rr.sv
// rr_arbiter_2: two-input round-robin picker, purely combinational.
//   req[1:0]   : request per channel
//   last_grant : index of the channel served most recently
//   en         : enables a decision; grant is 0 when low
//   grant[1:0] : one-hot winner, 0 when no request
// On a tie the channel that was not served last wins.
module rr_arbiter_2
    import udp_tx_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = ch_onehot(1'b0);
                2'b10:   grant = ch_onehot(1'b1);
                2'b11:   grant = ch_onehot(~last_grant);
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-granular arbiter sharing the UDP TX user input
// between two AXI-Stream sources. Before each packet the granted channel's
// UDP ports are loaded into the TX dynamic-port inputs, then the packet is
// passed through unchanged, then a fixed idle gap lets the TX buffer drain.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   s_axis_ch0, s_axis_ch1   : source streams (user[15:0] = payload length)
//   m_axis_user              : stream to UDP TX
//   o_dymanic_src/dst_port   : port values, valid strobes pulse for one cycle
//   o_grant                  : one-hot active channel, 0 when none
//   o_busy                   : high whenever the FSM is not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | sample both valids, pick a winner, latch grant and ports
// CFG      | port load strobes high for this single cycle
// WAIT_RDY | hold until TX is ready so the port load lands first
// FWD      | combinational pass-through of the granted channel
// GAP      | count down the inter-packet gap, grant still held
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter logic [15:0] P_CH0_SRC_PORT = 16'h0808,
    parameter logic [15:0] P_CH0_DST_PORT = 16'h0808,
    parameter logic [15:0] P_CH1_SRC_PORT = 16'h0809,
    parameter logic [15:0] P_CH1_DST_PORT = 16'h0809,
    parameter int unsigned P_GAP_CYCLES   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    udp_tx_axis_if.slave         s_axis_ch0,
    udp_tx_axis_if.slave         s_axis_ch1,
    udp_tx_axis_if.master        m_axis_user,
    output logic [15:0]          o_dymanic_src_port,
    output logic                 o_dymanic_src_valid,
    output logic [15:0]          o_dymanic_dst_port,
    output logic                 o_dymanic_dst_valid,
    output logic [1:0]           o_grant,
    output logic                 o_busy
);

    // The counter holds the remaining GAP cycles after the current one.
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(P_GAP_CYCLES - 1);

    arb_state_t           state;
    logic                 rr_last;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [1:0]           pick;
    logic                 sel_valid;
    logic                 sel_last;

    rr_arbiter_2 u_rr (
        .req        ({s_axis_ch1.valid, s_axis_ch0.valid}),
        .last_grant (rr_last),
        .en         (state == ST_IDLE),
        .grant      (pick)
    );

    assign sel_valid = o_grant[CH1] ? s_axis_ch1.valid : s_axis_ch0.valid;
    assign sel_last  = o_grant[CH1] ? s_axis_ch1.last  : s_axis_ch0.last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= ST_IDLE;
            rr_last             <= 1'b1;
            gap_cnt             <= '0;
            o_grant             <= 2'b00;
            o_busy              <= 1'b0;
            o_dymanic_src_port  <= P_CH0_SRC_PORT;
            o_dymanic_dst_port  <= P_CH0_DST_PORT;
            o_dymanic_src_valid <= 1'b0;
            o_dymanic_dst_valid <= 1'b0;
        end else begin
            o_dymanic_src_valid <= 1'b0;
            o_dymanic_dst_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick != 2'b00) begin
                        // Ports and strobes are registered here so they are
                        // visible exactly during the CFG cycle.
                        o_grant             <= pick;
                        rr_last             <= pick[CH1];
                        o_busy              <= 1'b1;
                        o_dymanic_src_port  <= pick[CH1] ? P_CH1_SRC_PORT : P_CH0_SRC_PORT;
                        o_dymanic_dst_port  <= pick[CH1] ? P_CH1_DST_PORT : P_CH0_DST_PORT;
                        o_dymanic_src_valid <= 1'b1;
                        o_dymanic_dst_valid <= 1'b1;
                        state               <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (m_axis_user.ready) begin
                        state <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (sel_valid && m_axis_user.ready && sel_last) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        o_grant <= 2'b00;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency stream mux; everything is quiet outside FWD.
    always_comb begin
        m_axis_user.data  = '0;
        m_axis_user.user  = '0;
        m_axis_user.keep  = '0;
        m_axis_user.last  = 1'b0;
        m_axis_user.valid = 1'b0;
        s_axis_ch0.ready  = 1'b0;
        s_axis_ch1.ready  = 1'b0;
        if (state == ST_FWD) begin
            if (o_grant[CH1]) begin
                m_axis_user.data  = s_axis_ch1.data;
                m_axis_user.user  = s_axis_ch1.user;
                m_axis_user.keep  = s_axis_ch1.keep;
                m_axis_user.last  = s_axis_ch1.last;
                m_axis_user.valid = s_axis_ch1.valid;
                s_axis_ch1.ready  = m_axis_user.ready;
            end else begin
                m_axis_user.data  = s_axis_ch0.data;
                m_axis_user.user  = s_axis_ch0.user;
                m_axis_user.keep  = s_axis_ch0.keep;
                m_axis_user.last  = s_axis_ch0.last;
                m_axis_user.valid = s_axis_ch0.valid;
                s_axis_ch0.ready  = m_axis_user.ready;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: a cycle table for a single ch0
// packet, randomized traffic checked against a packet-level reference model,
// and a reset-mid-packet sequence.
module tb_udp_tx_arbiter;
    localparam int P_GAP = 4;
    localparam int NPKT  = 40;
    localparam int M_WAIT = 0, M_ACTIVE = 1, M_GAP = 2;

    logic        clk;
    logic        rst;
    logic [15:0] src_port, dst_port;
    logic        src_valid, dst_valid;
    logic [1:0]  grant;
    logic        busy;

    udp_tx_axis_if ch0_if ();
    udp_tx_axis_if ch1_if ();
    udp_tx_axis_if m_if ();

    udp_tx_arbiter #(.P_GAP_CYCLES(P_GAP)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .s_axis_ch0          (ch0_if),
        .s_axis_ch1          (ch1_if),
        .m_axis_user         (m_if),
        .o_dymanic_src_port  (src_port),
        .o_dymanic_src_valid (src_valid),
        .o_dymanic_dst_port  (dst_port),
        .o_dymanic_dst_valid (dst_valid),
        .o_grant             (grant),
        .o_busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] user;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t q[2][$];

    // ---------------- reference model state ----------------
    int mode, last_ch, cur_ch, arb_cyc, gap_left, cyc, last_beat_cyc;
    bit fwd, first_beat;
    bit fire0, fire1;

    function automatic logic [15:0] port_of(input int ch);
        return (ch == 1) ? 16'h0809 : 16'h0808;
    endfunction

    task automatic model_init();
        mode = M_WAIT; last_ch = 1; cur_ch = 0; arb_cyc = 0;
        gap_left = 0; cyc = 0; last_beat_cyc = -1; fwd = 0; first_beat = 0;
    endtask

    task automatic model_step();
        logic [1:0] sv, rd;
        logic       mfire;
        beat_t      b;
        sv = {ch1_if.valid, ch0_if.valid};
        rd = {ch1_if.ready, ch0_if.ready};
        fire0 = sv[0] & rd[0];
        fire1 = sv[1] & rd[1];
        mfire = m_if.valid & m_if.ready;
        case (mode)
            M_WAIT: begin
                chk("idle_busy", 64'(busy), 64'd0);
                chk("idle_grant", 64'(grant), 64'd0);
                chk("idle_mvalid", 64'(m_if.valid), 64'd0);
                chk("idle_ready", 64'(rd), 64'd0);
                chk("idle_strobe", 64'({src_valid, dst_valid}), 64'd0);
                if (sv != 2'b00) begin
                    if (sv == 2'b11) cur_ch = 1 - last_ch;
                    else cur_ch = sv[1] ? 1 : 0;
                    last_ch = cur_ch; arb_cyc = cyc; mode = M_ACTIVE;
                    fwd = 0; first_beat = 1;
                end
            end
            M_ACTIVE: begin
                chk("act_busy", 64'(busy), 64'd1);
                chk("act_grant", 64'(grant), (cur_ch == 1) ? 64'd2 : 64'd1);
                if (cyc == arb_cyc + 1) begin
                    chk("cfg_src_valid", 64'(src_valid), 64'd1);
                    chk("cfg_dst_valid", 64'(dst_valid), 64'd1);
                    chk("cfg_src_port", 64'(src_port), 64'(port_of(cur_ch)));
                    chk("cfg_dst_port", 64'(dst_port), 64'(port_of(cur_ch)));
                end else begin
                    chk("act_strobe_low", 64'({src_valid, dst_valid}), 64'd0);
                end
                if (fwd) begin
                    chk("fwd_mvalid", 64'(m_if.valid), 64'(sv[cur_ch]));
                    chk("fwd_ready_granted", 64'(rd[cur_ch]), 64'(m_if.ready));
                    chk("fwd_ready_other", 64'(rd[1-cur_ch]), 64'd0);
                    if (mfire) begin
                        b = q[cur_ch][0];
                        chk("beat_data", m_if.data, b.data);
                        chk("beat_user", 64'(m_if.user), 64'(b.user));
                        chk("beat_keep", 64'(m_if.keep), 64'(b.keep));
                        chk("beat_last", 64'(m_if.last), 64'(b.last));
                        if (first_beat && last_beat_cyc >= 0)
                            chk("pkt_spacing_ok", 64'((cyc - last_beat_cyc) >= P_GAP + 3), 64'd1);
                        first_beat = 0;
                        if (b.last) begin
                            mode = M_GAP; gap_left = P_GAP; last_beat_cyc = cyc;
                        end
                    end
                end else begin
                    chk("pre_fwd_mvalid", 64'(m_if.valid), 64'd0);
                    chk("pre_fwd_ready", 64'(rd), 64'd0);
                    if (cyc >= arb_cyc + 2 && m_if.ready) fwd = 1;
                end
            end
            default: begin
                chk("gap_busy", 64'(busy), 64'd1);
                chk("gap_mvalid", 64'(m_if.valid), 64'd0);
                chk("gap_ready", 64'(rd), 64'd0);
                chk("gap_strobe", 64'({src_valid, dst_valid}), 64'd0);
                gap_left--;
                if (gap_left == 0) mode = M_WAIT;
            end
        endcase
    endtask

    task automatic drive_ch(input int ch, input int vprob);
        beat_t b;
        logic  v;
        v = (q[ch].size() > 0) && ($urandom_range(99) < vprob);
        b = v ? q[ch][0] : '0;
        if (ch == 0) begin
            ch0_if.valid = v; ch0_if.data = b.data; ch0_if.user = b.user;
            ch0_if.keep = b.keep; ch0_if.last = b.last;
        end else begin
            ch1_if.valid = v; ch1_if.data = b.data; ch1_if.user = b.user;
            ch1_if.keep = b.keep; ch1_if.last = b.last;
        end
    endtask

    task automatic rand_run(input int vprob, input int rprob, input int ncyc, input bit drain);
        int n = 0;
        while (n < ncyc && (!drain || q[0].size() > 0 || q[1].size() > 0)) begin
            drive_ch(0, vprob);
            drive_ch(1, vprob);
            m_if.ready = ($urandom_range(99) < rprob);
            @(negedge clk);
            model_step();
            @(posedge clk); #1;
            if (fire0) void'(q[0].pop_front());
            if (fire1) void'(q[1].pop_front());
            cyc++; n++;
        end
    endtask

    task automatic idle_inputs();
        ch0_if.valid = 0; ch0_if.last = 0; ch0_if.data = '0; ch0_if.user = '0; ch0_if.keep = '0;
        ch1_if.valid = 0; ch1_if.last = 0; ch1_if.data = '0; ch1_if.user = '0; ch1_if.keep = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); m_if.ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    typedef struct packed {
        logic        v0, l0, mr;
        logic [7:0]  keep;
        logic [63:0] data;
        logic [1:0]  e_grant;
        logic        e_busy, e_stb, e_rdy0, e_mv;
    } row_t;

    row_t rows[11];

    initial begin
        int    n;
        bit    seen;
        int    bidx;
        beat_t bt;
        int    len;

        rst = 1; idle_inputs(); m_if.ready = 0;
        @(posedge clk); #1;
        do_reset();

        // ---- reset state ----
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_readys", 64'({ch1_if.ready, ch0_if.ready}), 64'd0);
        chk("rst_mvalid", 64'(m_if.valid), 64'd0);
        chk("rst_mlast", 64'(m_if.last), 64'd0);
        chk("rst_mdata", m_if.data, 64'd0);
        chk("rst_ports", 64'({src_port, dst_port}), 64'h08080808);
        chk("rst_strobes", 64'({src_valid, dst_valid}), 64'd0);
        @(posedge clk); #1;

        // ---- single ch0 packet, cycle by cycle ----
        //          v0 l0 mr keep   data  grant busy stb rdy0 mv
        rows[0]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 64'hA, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[1]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 64'hA, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        rows[2]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 64'hA, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        rows[3]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 64'hA, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        rows[4]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 64'hB, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        rows[5]  = '{1'b1, 1'b1, 1'b1, 8'hF0, 64'hC, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        rows[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        rows[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        rows[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        rows[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        rows[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ch0_if.valid = rows[i].v0; ch0_if.last = rows[i].l0; ch0_if.keep = rows[i].keep;
            ch0_if.data = rows[i].data; ch0_if.user = 32'd20; m_if.ready = rows[i].mr;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(rows[i].e_grant));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(rows[i].e_busy));
            chk($sformatf("tbl%0d_src_valid", i), 64'(src_valid), 64'(rows[i].e_stb));
            chk($sformatf("tbl%0d_dst_valid", i), 64'(dst_valid), 64'(rows[i].e_stb));
            chk($sformatf("tbl%0d_ch0_ready", i), 64'(ch0_if.ready), 64'(rows[i].e_rdy0));
            chk($sformatf("tbl%0d_ch1_ready", i), 64'(ch1_if.ready), 64'd0);
            chk($sformatf("tbl%0d_mvalid", i), 64'(m_if.valid), 64'(rows[i].e_mv));
            if (rows[i].e_stb)
                chk($sformatf("tbl%0d_ports", i), 64'({src_port, dst_port}), 64'h08080808);
            if (rows[i].e_mv) begin
                chk($sformatf("tbl%0d_mdata", i), m_if.data, rows[i].data);
                chk($sformatf("tbl%0d_mlast", i), 64'(m_if.last), 64'(rows[i].l0));
                chk($sformatf("tbl%0d_mkeep", i), 64'(m_if.keep), 64'(rows[i].keep));
                chk($sformatf("tbl%0d_muser", i), 64'(m_if.user), 64'd20);
            end
            @(posedge clk); #1;
        end

        // ---- randomized traffic against the reference model ----
        for (int ch = 0; ch < 2; ch++) begin
            for (int p = 0; p < NPKT; p++) begin
                len = $urandom_range(6, 1);
                for (int b = 0; b < len; b++) begin
                    bt.data = {32'($urandom), 8'(ch), 8'(p), 16'(b)};
                    bt.user = {16'($urandom), 16'(len * 8)};
                    bt.last = (b == len - 1);
                    bt.keep = bt.last ? 8'($urandom_range(255, 1)) : 8'hFF;
                    q[ch].push_back(bt);
                end
            end
        end
        do_reset();
        model_init();
        rand_run(100, 100, 200, 1'b0);   // constant contention: strict alternation
        rand_run(70, 60, 12000, 1'b1);   // bubbles on both sides until drained
        chk("drain_ch0_empty", 64'(q[0].size()), 64'd0);
        chk("drain_ch1_empty", 64'(q[1].size()), 64'd0);
        idle_inputs(); m_if.ready = 0;

        // ---- reset in the middle of a packet ----
        do_reset();
        ch1_if.valid = 1; ch1_if.last = 1; ch1_if.data = 64'h1111; m_if.ready = 1;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            seen = ch1_if.valid && ch1_if.ready;
            @(posedge clk); #1;
            n++;
        end
        chk("rstmid_ch1_sent", 64'(seen), 64'd1);
        idle_inputs();
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_ports_ch1", 64'({src_port, dst_port}), 64'h08090809);
        @(posedge clk); #1;
        bidx = 0; n = 0;
        ch0_if.valid = 1; ch0_if.last = 0; ch0_if.keep = 8'hFF; ch0_if.data = 64'hA0;
        while (bidx < 1 && n < 20) begin
            @(negedge clk);
            if (ch0_if.valid && ch0_if.ready) bidx++;
            @(posedge clk); #1;
            ch0_if.data = 64'hA0 + 64'(bidx);
            n++;
        end
        chk("rstmid_first_beat", 64'(bidx), 64'd1);
        rst = 1;
        ch1_if.valid = 1; ch1_if.last = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstmid_grant", 64'(grant), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_readys", 64'({ch1_if.ready, ch0_if.ready}), 64'd0);
        chk("rstmid_mvalid", 64'(m_if.valid), 64'd0);
        chk("rstmid_ports", 64'({src_port, dst_port}), 64'h08080808);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_tie_grant", 64'(grant), 64'd1);
        chk("rstmid_tie_strobe", 64'({src_valid, dst_valid}), 64'd3);
        chk("rstmid_tie_ports", 64'({src_port, dst_port}), 64'h08080808);
        @(posedge clk); #1;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
Packet-granular two-requester arbiter in front of the UDP transmit path. Two user AXI-Stream sources (ch0, ch1) share one UDP TX input. Before each packet the arbiter pushes that channel's UDP source/destination ports into the UDP TX dynamic-port inputs. It then forwards the whole packet unchanged and holds an inter-packet gap so the downstream buffer can drain.

Parameters:
P_CH0_SRC_PORT, 16'h0808, UDP source port loaded for ch0 packets
P_CH0_DST_PORT, 16'h0808, UDP destination port loaded for ch0 packets
P_CH1_SRC_PORT, 16'h0809, UDP source port loaded for ch1 packets
P_CH1_DST_PORT, 16'h0809, UDP destination port loaded for ch1 packets
P_GAP_CYCLES, 4, idle cycles enforced after each forwarded last beat (1..255)

Ports:
i_clk  in  1  single clock
i_rst  in  1  synchronous, active-high reset
s_axis_ch0_data/user/keep/last/valid  in  64/32/8/1/1  ch0 stream; user[15:0] = payload byte length
s_axis_ch0_ready  out  1  ch0 ready
s_axis_ch1_data/user/keep/last/valid  in  64/32/8/1/1  ch1 stream, same format
s_axis_ch1_ready  out  1  ch1 ready
m_axis_user_data/user/keep/last/valid  out  64/32/8/1/1  to UDP TX user input
m_axis_user_ready  in  1  from UDP TX
o_dymanic_src_port  out  16  port value for UDP TX
o_dymanic_src_valid  out  1  one-cycle load strobe
o_dymanic_dst_port  out  16  port value for UDP TX
o_dymanic_dst_valid  out  1  one-cycle load strobe
o_grant  out  2  one-hot active channel, 0 when none
o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - state=IDLE; rr pointer=ch1, so ch0 wins the first tie.
  - Gap counter=0; o_grant=0; o_busy=0.
  - Both readys=0; m valid=0, last=0; data/user/keep=0.
  - Port outputs=P_CH0_*; both port strobes=0.
  - Reset mid-packet aborts immediately; requesters must restart their packet.
- States: IDLE -> CFG -> WAIT_RDY -> FWD -> GAP -> IDLE.
- IDLE:
  - Arbitration samples chN_valid at the clock edge.
  - One channel valid: grant it.
  - Both valid: grant the channel other than the rr pointer.
  - Grant is latched into o_grant and the rr pointer is updated to the winner; next state CFG.
  - A valid that drops after sampling does not revoke the grant.
- CFG (exactly 1 cycle): drive the granted channel's src/dst ports and pulse both strobes for 1 cycle. Next state WAIT_RDY.
- WAIT_RDY: stay until m_axis_user_ready=1, then go to FWD. Guarantees the port load lands before the first beat.
- FWD: zero-latency combinational pass-through of the granted channel.
  - m data/user/keep/last/valid = granted s signals.
  - s_grantedN_ready = m_axis_user_ready.
  - Non-granted ready=0.
  - Outside FWD, all readys=0 and m valid=0.
  - A beat transfers when valid&ready. A valid gap mid-packet is a stall; the grant is held.
  - Transfer with last=1 -> GAP, gap counter loaded with P_GAP_CYCLES-1.
- GAP: decrement each cycle. At 0 -> IDLE; arbitration happens on the IDLE cycle, so minimum spacing is P_GAP_CYCLES+3 cycles between packets.
- Ready low in FWD: hold everything; no timeout.
- Single-beat packet (last on the first beat): FWD lasts one transfer cycle, then GAP.
- user, keep and last are forwarded untouched. The arbiter does no length checking.
- Gap counter is 8 bits wide.

Decomposition:
- Shared package udp_tx_arb_pkg:
  - State encoding (IDLE/CFG/WAIT_RDY/FWD/GAP, 3 bits).
  - Channel index constants CH0=0, CH1=1.
  - Gap counter width (8).
- One natural sub-module, rr_arbiter_2: 2-input round-robin picker. Inputs req[1:0], last grant, update enable. Output one-hot grant. Reusable when the channel count grows.
- The FSM and stream mux stay in udp_tx_arbiter.

Test Plan:
- Single ch0 packet, user[15:0]=16'd20, 3 beats, last keep=8'hF0, m_ready=1 -> one-cycle strobes with ports 0808/0808; FWD starts 2 cycles after grant; 3 identical beats out; ch1_ready stays 0.
- ch0 and ch1 both valid in the same cycle after reset -> ch0 served first, ch1 next. Repeat with both valid again -> ch0 then ch1 alternate (ch1 pointer tie rule); no back-to-back double grant to one channel.
- Back-to-back ch1 packets, P_GAP_CYCLES=4 -> last beat to next first beat is ≥7 cycles; o_busy falls for exactly 1 IDLE cycle between packets.
- m_ready held low for 5 cycles during CFG/WAIT_RDY, then toggled 1/0 in FWD -> no beats issued before ready; data is never duplicated or dropped; the beat count out equals the count in.
- ch0 valid de-asserted for 3 cycles mid-packet -> m valid=0 for those cycles; o_grant stays 01; ch1 (valid) is not granted until ch0 last plus gap.
- i_rst pulsed for 1 cycle on the 2nd beat of a 4-beat packet -> the next cycle shows IDLE, all readys 0, m valid 0, ports 0808. The next request is granted normally, with ch0 winning a tie.
